reaction_sequencer: RTL and testbench
=====================================

REACTION_SEQUENCER -- requirements
Module: reaction_sequencer

Interface
REQ-001 The block SHALL have parameter MIN_DELAY_MS, default 1000, meaning the fixed portion of the pre-stimulus delay in ms ticks.
REQ-002 The block SHALL have parameter TIMEOUT_MS, default 9999, meaning the reaction-time saturation and timeout limit in ms ticks.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have the port start, input, 1 bit: a one-cycle request to begin a round.
REQ-006 The block SHALL have the port react, input, 1 bit: a one-cycle player response, pre-synchronised and edge-detected upstream.
REQ-007 The block SHALL have the port tick_ms, input, 1 bit: a one-cycle strobe once per millisecond.
REQ-008 The block SHALL have the port lfsr_val, input, 12 bits: the current 12-bit LFSR state.
REQ-009 The block SHALL have the port lfsr_step, output, 1 bit: a one-cycle pulse that advances the LFSR.
REQ-010 The block SHALL have the port led_on, output, 1 bit: the stimulus indicator.
REQ-011 The block SHALL have the port busy, output, 1 bit: high while in SEED, WAIT or ARMED.
REQ-012 The block SHALL have the port done, output, 1 bit: high while in RESULT.
REQ-013 The block SHALL have the port false_start, output, 1 bit: high while in FAULT.
REQ-014 The block SHALL have the port timeout, output, 1 bit: high in RESULT when the round ended by saturation.
REQ-015 The block SHALL have the port time_ms, output, 14 bits: the measured reaction time.
REQ-016 The block SHALL have the port best_ms, output, 14 bits: the best valid reaction time since reset.

Function
REQ-017 The FSM SHALL have exactly six states: IDLE, SEED, WAIT, ARMED, RESULT, FAULT.
REQ-018 In IDLE, start SHALL move the FSM to SEED, and react SHALL be ignored.
REQ-019 SEED SHALL last exactly 2 cycles: lfsr_step=1 in the first cycle and 0 in the second; at the end of the second cycle the FSM SHALL load delay_cnt = MIN_DELAY_MS + lfsr_val (unsigned, 13-bit minimum) and move to WAIT.
REQ-020 In WAIT, each tick_ms SHALL decrement delay_cnt; a tick that takes delay_cnt from 1 to 0 SHALL move the FSM to ARMED on that edge.
REQ-021 In WAIT, react SHALL move the FSM to FAULT; react coincident with the expiring tick SHALL also go to FAULT (react wins).
REQ-022 ARMED entry SHALL clear time_ms to 0; led_on SHALL equal 1 only in ARMED.
REQ-023 In ARMED, each tick_ms SHALL increment time_ms by 1.
REQ-024 In ARMED, react SHALL move the FSM to RESULT with time_ms frozen; react coincident with tick_ms SHALL NOT increment time_ms.
REQ-025 In ARMED, a tick that brings time_ms to TIMEOUT_MS SHALL move the FSM to RESULT with timeout=1; time_ms SHALL never exceed TIMEOUT_MS.
REQ-026 On entry to RESULT with timeout=0 and time_ms < best_ms, best_ms SHALL load time_ms; equal values SHALL NOT update best_ms, and a timeout SHALL never update it.
REQ-027 RESULT and FAULT SHALL hold until start, which SHALL clear timeout and false_start and move the FSM to SEED.
REQ-028 start SHALL be ignored in SEED, WAIT and ARMED.
REQ-029 lfsr_step SHALL be 0 outside the first SEED cycle: exactly one pulse per round.
REQ-030 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-031 Asserting rst_n=0 SHALL immediately, without waiting for clk, force the FSM to IDLE, clear delay_cnt, and set lfsr_step, led_on, busy, done, false_start and timeout to 0, time_ms to 0, and best_ms to TIMEOUT_MS.
REQ-032 Reset asserted mid-round, in any state, SHALL abandon the round with the same values as REQ-031; best_ms SHALL be lost.
REQ-033 After release, the first active edge SHALL see the FSM in IDLE.

Verification
REQ-034 The bench SHALL cover a normal round: lfsr_val=12'h010, start, react 250 ticks after led_on rises -> one lfsr_step pulse, led_on after exactly 1016 ticks, done=1, time_ms=250, best_ms=250.
REQ-035 The bench SHALL cover best tracking: after REQ-034, a second round with reaction 300 -> best_ms stays 250; a third with reaction 120 -> best_ms=120; a repeat of 120 -> no change.
REQ-036 The bench SHALL cover false start: react 500 ticks into WAIT -> false_start=1, led_on never asserted, best_ms unchanged; start -> SEED, false_start=0.
REQ-037 The bench SHALL cover timeout: no react in ARMED -> after 9999 ticks done=1, timeout=1, time_ms=9999, best_ms unchanged.
REQ-038 The bench SHALL cover simultaneous events: react on the same cycle as the expiring WAIT tick -> FAULT; react with tick_ms in ARMED at time_ms=40 -> time_ms=40.
REQ-039 The bench SHALL cover reset mid-ARMED: rst_n low between clock edges -> outputs take their reset values asynchronously, best_ms=9999, and start after release -> normal round.

Source files
------------

// File: rtl/reaction_sequencer.sv
// Reaction-time game sequencer: seeds a random pre-stimulus delay, lights the LED,
// measures the player's response in ms ticks and tracks the best valid time.
`timescale 1ns/1ps

module reaction_sequencer #(
    parameter int MIN_DELAY_MS = 1000,
    parameter int TIMEOUT_MS   = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        react,
    input  logic        tick_ms,
    input  logic [11:0] lfsr_val,
    output logic        lfsr_step,
    output logic        led_on,
    output logic        busy,
    output logic        done,
    output logic        false_start,
    output logic        timeout,
    output logic [13:0] time_ms,
    output logic [13:0] best_ms
);

    // The delay counter must hold MIN_DELAY_MS plus the largest 12-bit LFSR value.
    localparam int DW_RAW = $clog2(MIN_DELAY_MS + 4096);
    localparam int DW     = (DW_RAW > 13) ? DW_RAW : 13;

    localparam logic [DW-1:0] MIN_DELAY_VAL = DW'(MIN_DELAY_MS);
    localparam logic [13:0]   TIMEOUT_VAL   = 14'(TIMEOUT_MS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_WAIT,
        S_ARMED,
        S_RESULT,
        S_FAULT
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_seed_ph;
    logic          w_seed_ph_nxt;
    logic [DW-1:0] r_delay_cnt;
    logic [DW-1:0] w_delay_nxt;
    logic [13:0]   r_time;
    logic [13:0]   w_time_nxt;
    logic [13:0]   w_time_inc;
    logic [13:0]   r_best;
    logic [13:0]   w_best_nxt;
    logic          r_timeout;
    logic          w_timeout_nxt;

    logic          r_lfsr_step;
    logic          r_led_on;
    logic          r_busy;
    logic          r_done;
    logic          r_false_start;

    assign w_time_inc = r_time + 14'd1;

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_seed_ph_nxt = r_seed_ph;
        w_delay_nxt   = r_delay_cnt;
        w_time_nxt    = r_time;
        w_best_nxt    = r_best;
        w_timeout_nxt = r_timeout;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt   = S_SEED;
                    w_seed_ph_nxt = 1'b0;
                end
            end

            S_SEED: begin
                // Second SEED cycle samples the LFSR after the step has taken effect.
                if (!r_seed_ph) begin
                    w_seed_ph_nxt = 1'b1;
                end else begin
                    w_seed_ph_nxt = 1'b0;
                    w_delay_nxt   = MIN_DELAY_VAL + DW'(lfsr_val);
                    w_state_nxt   = S_WAIT;
                end
            end

            S_WAIT: begin
                if (react) begin
                    w_state_nxt = S_FAULT;
                    w_delay_nxt = '0;
                end else if (tick_ms) begin
                    if (r_delay_cnt <= DW'(1)) begin
                        w_delay_nxt = '0;
                        w_time_nxt  = '0;
                        w_state_nxt = S_ARMED;
                    end else begin
                        w_delay_nxt = r_delay_cnt - DW'(1);
                    end
                end
            end

            S_ARMED: begin
                // A response in the same cycle as a tick freezes the count without that tick.
                if (react) begin
                    w_state_nxt = S_RESULT;
                    if (r_time < r_best) begin
                        w_best_nxt = r_time;
                    end
                end else if (tick_ms) begin
                    w_time_nxt = w_time_inc;
                    if (w_time_inc >= TIMEOUT_VAL) begin
                        w_time_nxt    = TIMEOUT_VAL;
                        w_timeout_nxt = 1'b1;
                        w_state_nxt   = S_RESULT;
                    end
                end
            end

            S_RESULT, S_FAULT: begin
                if (start) begin
                    w_timeout_nxt = 1'b0;
                    w_seed_ph_nxt = 1'b0;
                    w_state_nxt   = S_SEED;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: reset is asynchronous; the sensitivity list carries negedge rst_n so the
    // round is abandoned immediately, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_seed_ph     <= 1'b0;
            r_delay_cnt   <= '0;
            r_time        <= '0;
            r_best        <= TIMEOUT_VAL;
            r_timeout     <= 1'b0;
            r_lfsr_step   <= 1'b0;
            r_led_on      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_false_start <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            r_state       <= w_state_nxt;
            r_seed_ph     <= w_seed_ph_nxt;
            r_delay_cnt   <= w_delay_nxt;
            r_time        <= w_time_nxt;
            r_best        <= w_best_nxt;
            r_timeout     <= w_timeout_nxt;
            // Status flags are flops decoded from the next state, not from inputs.
            r_lfsr_step   <= (w_state_nxt == S_SEED) && !w_seed_ph_nxt;
            r_led_on      <= (w_state_nxt == S_ARMED);
            r_busy        <= (w_state_nxt == S_SEED) || (w_state_nxt == S_WAIT) ||
                             (w_state_nxt == S_ARMED);
            r_done        <= (w_state_nxt == S_RESULT);
            r_false_start <= (w_state_nxt == S_FAULT);
        end
    end

    assign lfsr_step   = r_lfsr_step;
    assign led_on      = r_led_on;
    assign busy        = r_busy;
    assign done        = r_done;
    assign false_start = r_false_start;
    assign timeout     = r_timeout;
    assign time_ms     = r_time;
    assign best_ms     = r_best;

endmodule

// File: tb/tb_reaction_sequencer.sv
// Self-checking bench for reaction_sequencer: table of full rounds plus directed
// sequences for false start, timeout, coincident events and mid-round reset.
`timescale 1ns/1ps

module tb_reaction_sequencer;

    localparam int MIN_DELAY = 1000;
    localparam int TMO       = 9999;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        react;
    logic        tick_ms;
    logic [11:0] lfsr_val;
    logic        lfsr_step;
    logic        led_on;
    logic        busy;
    logic        done;
    logic        false_start;
    logic        timeout;
    logic [13:0] time_ms;
    logic [13:0] best_ms;

    int n_checks = 0;
    int n_err    = 0;
    int step_cnt = 0;

    reaction_sequencer #(
        .MIN_DELAY_MS (MIN_DELAY),
        .TIMEOUT_MS   (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .react       (react),
        .tick_ms     (tick_ms),
        .lfsr_val    (lfsr_val),
        .lfsr_step   (lfsr_step),
        .led_on      (led_on),
        .busy        (busy),
        .done        (done),
        .false_start (false_start),
        .timeout     (timeout),
        .time_ms     (time_ms),
        .best_ms     (best_ms)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (lfsr_step === 1'b1) step_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [11:0] lfsr;
        int          react_after;
        int          exp_time;
        int          exp_best;
    } round_t;

    round_t rounds[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs are applied at a falling edge, held across one rising edge, and
    // outputs are observed at the next falling edge.
    task automatic drive(input logic s, input logic r, input logic t);
        start   = s;
        react   = r;
        tick_ms = t;
        @(negedge clk);
        start   = 1'b0;
        react   = 1'b0;
        tick_ms = 1'b0;
    endtask

    task automatic ticks_n(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic start_round(input logic [11:0] lv);
        lfsr_val = lv;
        drive(1'b1, 1'b0, 1'b0);
        check("seed1_lfsr_step", lfsr_step, 1);
        check("seed1_busy", busy, 1);
        check("seed1_done", done, 0);
        check("seed1_false_start", false_start, 0);
        check("seed1_timeout", timeout, 0);
        drive(1'b0, 1'b0, 1'b0);
        check("seed2_lfsr_step", lfsr_step, 0);
        check("seed2_busy", busy, 1);
        drive(1'b0, 1'b0, 1'b0);
        check("wait_led_off", led_on, 0);
    endtask

    task automatic wait_armed(output int ticks);
        bit seen;
        seen  = 1'b0;
        ticks = 0;
        while (!seen && ticks < 8192) begin
            drive(1'b0, 1'b0, 1'b1);
            ticks++;
            if (led_on === 1'b1) seen = 1'b1;
            else drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_round(input round_t r);
        int t;
        int steps_before;
        steps_before = step_cnt;
        start_round(r.lfsr);
        wait_armed(t);
        check("delay_ticks", t, MIN_DELAY + int'(r.lfsr));
        check("armed_time0", time_ms, 0);
        check("armed_busy", busy, 1);
        ticks_n(r.react_after);
        check("armed_time_count", time_ms, r.react_after);
        check("armed_led", led_on, 1);
        drive(1'b0, 1'b1, 1'b0);
        check("result_done", done, 1);
        check("result_time", time_ms, r.exp_time);
        check("result_best", best_ms, r.exp_best);
        check("result_led", led_on, 0);
        check("result_busy", busy, 0);
        check("result_timeout", timeout, 0);
        check("one_step_pulse", step_cnt - steps_before, 1);
    endtask

    initial begin
        int t;
        bit led_seen;

        rounds[0] = '{12'h010, 250, 250, 250};
        rounds[1] = '{12'h010, 300, 300, 250};
        rounds[2] = '{12'h010, 120, 120, 120};
        rounds[3] = '{12'h010, 120, 120, 120};
        rounds[4] = '{12'h005,  80,  80,  80};

        rst_n    = 1'b0;
        start    = 1'b0;
        react    = 1'b0;
        tick_ms  = 1'b0;
        lfsr_val = 12'h010;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_best", best_ms, TMO);
        check("rst_time", time_ms, 0);
        check("rst_lfsr_step", lfsr_step, 0);
        rst_n = 1'b1;

        // React in IDLE is ignored.
        drive(1'b0, 1'b1, 1'b0);
        check("idle_react_done", done, 0);
        check("idle_react_fault", false_start, 0);
        check("idle_react_busy", busy, 0);

        for (int i = 0; i < 5; i++) do_round(rounds[i]);

        // False start 500 ticks into WAIT.
        start_round(12'h010);
        led_seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            if (led_on === 1'b1) led_seen = 1'b1;
            drive(1'b0, 1'b0, 1'b0);
        end
        drive(1'b0, 1'b1, 1'b0);
        check("fs_false_start", false_start, 1);
        check("fs_led_never", {31'd0, led_seen | led_on}, 0);
        check("fs_busy", busy, 0);
        check("fs_best", best_ms, 80);
        ticks_n(3);
        check("fs_hold", false_start, 1);

        // Start from FAULT, then run into timeout.
        start_round(12'h010);
        wait_armed(t);
        check("to_delay_ticks", t, 1016);
        ticks_n(TMO - 1);
        check("to_pre_time", time_ms, TMO - 1);
        check("to_pre_done", done, 0);
        drive(1'b0, 1'b0, 1'b1);
        check("to_done", done, 1);
        check("to_timeout", timeout, 1);
        check("to_time", time_ms, TMO);
        check("to_best", best_ms, 80);
        check("to_led", led_on, 0);
        ticks_n(3);
        check("to_saturate", time_ms, TMO);

        // React coincident with the expiring WAIT tick.
        start_round(12'h010);
        ticks_n(1015);
        check("sim_wait_led", led_on, 0);
        drive(1'b0, 1'b1, 1'b1);
        check("sim_wait_fault", false_start, 1);
        check("sim_wait_led_off", led_on, 0);

        // Start ignored in ARMED; react with tick at time_ms=40.
        start_round(12'h010);
        wait_armed(t);
        t = step_cnt;
        drive(1'b1, 1'b0, 1'b0);
        check("armed_start_ignored_led", led_on, 1);
        check("armed_start_ignored_step", step_cnt - t, 0);
        ticks_n(40);
        drive(1'b0, 1'b1, 1'b1);
        check("sim_armed_time", time_ms, 40);
        check("sim_armed_done", done, 1);
        check("sim_armed_best", best_ms, 40);

        // Asynchronous reset in the middle of ARMED.
        start_round(12'h010);
        wait_armed(t);
        ticks_n(30);
        check("pre_rst_time", time_ms, 30);
        #2 rst_n = 1'b0;
        #1;
        check("arst_led", led_on, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_time", time_ms, 0);
        check("arst_best", best_ms, TMO);
        check("arst_timeout", timeout, 0);
        check("arst_false_start", false_start, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0);
        check("post_rst_idle", busy, 0);
        do_round('{12'h010, 100, 100, 100});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
